axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-beat AXI3-style slave backed by a 2^MEM_AW x 32-bit RAM.
//
// The read and write paths are independent FSMs that run concurrently. All
// handshake outputs are registered. The RAM itself is not reset, so contents
// survive a reset pulse.
//
// Ports
//   aclk, aresetn       clock, asynchronous active-low reset
//   ar*  / arready      read address channel (only arid and word index used)
//   r*   / rready       read data channel (always OKAY, always last)
//   aw*  / awready      write address channel (only awid and word index used)
//   w*   / wready       write data channel (only wdata and wstrb used)
//   b*   / bready       write response channel (always OKAY)
module axi_ram_slave #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  // AR
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // R
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // AW
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // W
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth = 1 << MEM_AW;
  localparam int unsigned CntW  = 8;

  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
  typedef enum logic [1:0] {WIdle, WMem, WWait, WResp} wr_state_e;

  logic [31:0] mem [Depth];

  rd_state_e         rd_state;
  logic [CntW-1:0]   rd_cnt;
  logic [MEM_AW-1:0] rd_idx;

  wr_state_e         wr_state;
  logic [CntW-1:0]   wr_cnt;
  logic [MEM_AW-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              aw_got;
  logic              w_got;

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Every transfer is a single OKAY beat.
  assign rresp = 2'b00;
  assign bresp = 2'b00;
  assign rlast = rvalid;

  // Burst/attribute fields and the out-of-range address bits are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                           araddr[31:MEM_AW+2], araddr[1:0],
                           awlen, awsize, awburst, awlock, awcache, awprot,
                           awaddr[31:MEM_AW+2], awaddr[1:0], wid, wlast};

  // Read FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RIdle;
      rd_cnt   <= '0;
      rd_idx   <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
    end else begin
      unique case (rd_state)
        RIdle: begin
          arready <= 1'b1;
          if (ar_hs) begin
            rid      <= arid;
            rd_idx   <= araddr[MEM_AW+1:2];
            rd_cnt   <= CntW'(RD_LAT - 1);
            arready  <= 1'b0;
            rd_state <= RWait;
          end
        end
        RWait: begin
          if (rd_cnt == '0) begin
            // Reads the pre-write value if the write FSM updates this word on the same edge.
            rdata    <= mem[rd_idx];
            rvalid   <= 1'b1;
            rd_state <= RResp;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        RResp: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= RIdle;
          end
        end
        default: rd_state <= RIdle;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WIdle;
      wr_cnt   <= '0;
      wr_idx   <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
    end else begin
      unique case (wr_state)
        WIdle: begin
          if (aw_got && w_got) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            wr_state <= WMem;
          end else begin
            if (aw_hs) begin
              bid    <= awid;
              wr_idx <= awaddr[MEM_AW+1:2];
              aw_got <= 1'b1;
            end
            if (w_hs) begin
              wr_data <= wdata;
              wr_strb <= wstrb;
              w_got   <= 1'b1;
            end
            // Each channel stays closed once captured until the pair is complete.
            awready <= ~(aw_got | aw_hs);
            wready  <= ~(w_got | w_hs);
          end
        end
        WMem: begin
          wr_cnt   <= CntW'(WR_LAT - 1);
          wr_state <= WWait;
        end
        WWait: begin
          if (wr_cnt == '0) begin
            bvalid   <= 1'b1;
            wr_state <= WResp;
          end else begin
            wr_cnt <= wr_cnt - 1'b1;
          end
        end
        WResp: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= WIdle;
          end
        end
        default: wr_state <= WIdle;
      endcase
    end
  end

  // RAM write port; no reset so contents persist across aresetn pulses.
  always_ff @(posedge aclk) begin
    if (wr_state == WMem) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave with a response scoreboard: expected R and B
// responses are queued when a request is issued and compared when the DUT responds.
module tb_axi_ram_slave;

  localparam int unsigned MemAw = 10;
  localparam int unsigned RdLat = 4;
  localparam int unsigned WrLat = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b1;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  axi_ram_slave #(
    .MEM_AW(MemAw),
    .RD_LAT(RdLat),
    .WR_LAT(WrLat)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] rd_q[$];  // {rid, rdata}
  logic [3:0]  b_q[$];   // bid

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hit, w_hit;
    b_q.push_back(id);
    awaddr = addr; awid = id; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      tick();
      if (aw_hit) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hit) begin wvalid = 1'b0; w_done = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
  endtask

  task automatic get_b();
    bit seen = 0;
    logic [3:0] e;
    for (int i = 0; i < 100; i++) begin
      if (bvalid) begin seen = 1; break; end
      tick();
    end
    check("b_seen", 32'(seen), 32'd1);
    if (seen) begin
      e = b_q.pop_front();
      check("bid", 32'(bid), 32'(e));
      check("bresp", 32'(bresp), 32'd0);
      bready = 1'b1;
      tick();
      check("b_done", 32'(bvalid), 32'd0);
      check("w_ready_back", 32'({awready, wready}), 32'd3);
    end
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] exp);
    bit ok = 0;
    rd_q.push_back({id, exp});
    araddr = addr; arid = id; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (arready) begin ok = 1; tick(); break; end
      tick();
    end
    arvalid = 1'b0;
    check("ar_accept", 32'(ok), 32'd1);
  endtask

  task automatic collect_r(input int hold, output int lat);
    bit seen = 0;
    logic [35:0] e;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (rvalid) begin seen = 1; break; end
      tick();
      lat++;
    end
    check("r_seen", 32'(seen), 32'd1);
    if (seen) begin
      e = rd_q.pop_front();
      check("rid", 32'(rid), 32'(e[35:32]));
      check("rdata", rdata, e[31:0]);
      check("rresp_rlast", 32'({rresp, rlast}), 32'd1);
      for (int i = 0; i < hold; i++) begin
        tick();
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, e[31:0]);
        check("r_hold_id", 32'(rid), 32'(e[35:32]));
        check("r_hold_arready", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      tick();
      check("r_done", 32'(rvalid), 32'd0);
      check("arready_back", 32'(arready), 32'd1);
    end
  endtask

  task automatic read(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] exp,
                      input int hold);
    int lat;
    issue_ar(addr, id, exp);
    collect_r(hold, lat);
    check("rd_latency", 32'(lat), RdLat);
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset state
    #2;
    check("rst_readies", 32'({arready, awready, wready}), 32'd0);
    check("rst_valids", 32'({rvalid, bvalid, rlast}), 32'd0);
    check("rst_ids", 32'({rid, bid}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", 32'({rresp, bresp}), 32'd0);
    #20;
    aresetn = 1'b1;  // mid-cycle release
    #1;
    check("readies_before_edge", 32'({arready, awready, wready}), 32'd0);
    tick();
    check("readies_after_edge", 32'({arready, awready, wready}), 32'd7);

    // Full-word write then read
    issue_write(32'h10, 32'hDEAD_BEEF, 4'hF, 4'd1);
    get_b();
    read(32'h10, 4'd0, 32'hDEAD_BEEF, 0);

    // Byte-lane strobes, including an empty strobe
    issue_write(32'h10, 32'h0000_1122, 4'h3, 4'd2);
    get_b();
    read(32'h10, 4'd3, 32'hDEAD_1122, 0);
    issue_write(32'h10, 32'hFFFF_FFFF, 4'h0, 4'd4);
    get_b();
    read(32'h10, 4'd3, 32'hDEAD_1122, 0);
    issue_write(32'h10, 32'hA500_0000, 4'h8, 4'd9);
    get_b();
    read(32'h10, 4'd10, 32'hA5AD_1122, 0);

    // W well ahead of AW: W captured, then held off until AW arrives
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    check("w_first_ready", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    check("w_held", 32'(wready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w_wait_no_b", 32'(bvalid), 32'd0);
      check("w_wait_ready", 32'({awready, wready}), 32'd2);
    end
    b_q.push_back(4'd5);
    awaddr = 32'h40; awid = 4'd5; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    get_b();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_b", 32'(bvalid), 32'd0);
    end
    read(32'h40, 4'd5, 32'h0BAD_F00D, 0);

    // Read backpressure for 5 cycles
    rready = 1'b0;
    read(32'h10, 4'd6, 32'hA5AD_1122, 5);

    // Address aliasing above the RAM size
    issue_write(32'h0000_1004, 32'h1234_5678, 4'hF, 4'd7);
    get_b();
    read(32'h0000_0004, 4'd7, 32'h1234_5678, 0);

    // Read sample and RAM write on the same edge: read sees old data
    issue_write(32'h20, 32'h1111_1111, 4'hF, 4'd1);
    get_b();
    bready = 1'b0;
    rd_q.push_back({4'd2, 32'h1111_1111});
    araddr = 32'h20; arid = 4'd2; arvalid = 1'b1;
    check("coll_arready", 32'(arready), 32'd1);
    tick();              // AR handshake, sample lands RdLat edges later
    arvalid = 1'b0;
    tick();
    check("coll_wready", 32'({awready, wready}), 32'd3);
    b_q.push_back(4'd3);
    awaddr = 32'h20; awid = 4'd3; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();              // AW+W handshake; RAM written two edges later
    awvalid = 1'b0; wvalid = 1'b0;
    collect_r(0, lat);
    get_b();
    read(32'h20, 4'd4, 32'h2222_2222, 0);

    // Reset while a read is waiting and a write response is pending
    bready = 1'b0;
    issue_write(32'h80, 32'hCAFE_BABE, 4'hF, 4'd7);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (bvalid) begin seen = 1; break; end
      tick();
    end
    check("pre_rst_bvalid", 32'(seen), 32'd1);
    issue_ar(32'h10, 4'd8, 32'h0);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_readies", 32'({arready, awready, wready}), 32'd0);
    check("mid_rst_valids", 32'({rvalid, bvalid}), 32'd0);
    rd_q.delete();
    b_q.delete();
    #2;
    aresetn = 1'b1;
    bready = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_resp_after_rst", 32'({rvalid, bvalid}), 32'd0);
    end
    read(32'h80, 4'd9, 32'hCAFE_BABE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
